// File: rtl/timer_irq_if.sv
// Register-bus bundle for timer_irq: word-addressed write port with byte
// enables and a combinational read-back path.
interface timer_irq_if;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (
        output addr,
        output we,
        output be,
        output din,
        input  dout
    );

    modport slave (
        input  addr,
        input  we,
        input  be,
        input  din,
        output dout
    );
endinterface

// File: rtl/timer_irq.sv
// Down-counting timer with one-shot / periodic modes and a maskable level
// interrupt; CTRL/PRESET writes take priority over the counting FSM.
module timer_irq (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        flag_q;

    logic [3:0]  ctrl_d;
    logic [31:0] preset_d;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        frozen;
    logic        ctrl_en;
    logic        mode_periodic;

    assign wr_ctrl       = bus.we && (bus.addr == ADDR_CTRL);
    assign wr_preset     = bus.we && (bus.addr == ADDR_PRESET);
    assign frozen        = wr_ctrl || wr_preset;
    assign ctrl_en       = ctrl_q[0];
    // MODE codes 2 and 3 fall back to one-shot behaviour.
    assign mode_periodic = (ctrl_q[2:1] == 2'b01);

    // Byte-masked merge of the write data into PRESET.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_preset_byte
            assign preset_d[gi*8 +: 8] = (wr_preset && bus.be[gi])
                                       ? bus.din[gi*8 +: 8]
                                       : preset_q[gi*8 +: 8];
        end
    endgenerate

    // Only the low nibble of byte 0 exists in CTRL.
    assign ctrl_d = (wr_ctrl && bus.be[0]) ? bus.din[3:0] : ctrl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            preset_q <= preset_d;
            if (frozen) begin
                ctrl_q <= ctrl_d;
                flag_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ctrl_en) begin
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_q <= preset_q;
                        state_q <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!ctrl_en) begin
                            state_q <= ST_IDLE;
                        end else if (count_q > 32'd1) begin
                            count_q <= count_q - 32'd1;
                        end else begin
                            // Covers PRESET=0 too: expire without wrapping.
                            count_q <= 32'd0;
                            flag_q  <= 1'b1;
                            state_q <= ST_INT;
                        end
                    end
                    ST_INT: begin
                        if (mode_periodic) begin
                            flag_q <= 1'b0;
                        end else begin
                            ctrl_q[0] <= 1'b0;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   bus.dout = {28'd0, ctrl_q};
            ADDR_PRESET: bus.dout = preset_q;
            ADDR_COUNT:  bus.dout = count_q;
            default:     bus.dout = 32'd0;
        endcase
    end

    assign irq = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: a vector table for the one-shot and register
// access paths, plus hand-written periodic, mask, pause and reset sequences.
module tb_timer_irq;

    logic clk;
    logic reset;
    logic irq;

    timer_irq_if bus_if ();

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [1:0]  chk_addr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[18];

    // Drive one cycle of inputs, let the rising edge take them, settle.
    task automatic step(input logic rst, input logic we, input logic [1:0] addr,
                        input logic [3:0] be, input logic [31:0] din);
        @(negedge clk);
        reset       = rst;
        bus_if.we   = we;
        bus_if.addr = addr;
        bus_if.be   = be;
        bus_if.din  = din;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus_if.we = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
    endtask

    task automatic chk_dout(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1;
        n_checks++;
        if (bus_if.dout === exp) n_pass++;
        else $display("FAIL %s: dout[addr %0d] = 0x%08h, expected 0x%08h", name, a, bus_if.dout, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        n_checks++;
        if (irq === exp) n_pass++;
        else $display("FAIL %s: irq = %b, expected %b", name, irq, exp);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'd0);
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        for (int a = 0; a < 4; a++) chk_dout(name, 2'(a), 32'd0);
        chk_irq(name, 1'b0);
    endtask

    initial begin
        reset       = 1'b0;
        bus_if.we   = 1'b0;
        bus_if.addr = 2'd0;
        bus_if.be   = 4'h0;
        bus_if.din  = 32'd0;

        //             we    addr  be     din            chk   exp_dout       irq
        vecs[0]  = '{1'b1, 2'd1, 4'hF, 32'd5,         2'd1, 32'd5,         1'b0}; // PRESET=5
        vecs[1]  = '{1'b1, 2'd0, 4'hF, 32'h9,         2'd0, 32'h9,         1'b0}; // E0
        vecs[2]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd0,         1'b0}; // E1 -> LOAD
        vecs[3]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd5,         1'b0}; // E2
        vecs[4]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd4,         1'b0}; // E3
        vecs[5]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd3,         1'b0}; // E4
        vecs[6]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd2,         1'b0}; // E5
        vecs[7]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd1,         1'b0}; // E6
        vecs[8]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd0,         1'b1}; // E7 expiry
        vecs[9]  = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd0, 32'h8,         1'b1}; // E8 EN cleared
        vecs[10] = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd2, 32'd0,         1'b1}; // flag holds
        vecs[11] = '{1'b1, 2'd1, 4'hF, 32'h11223344,  2'd1, 32'h11223344,  1'b0}; // write clears flag
        vecs[12] = '{1'b1, 2'd1, 4'h2, 32'hAABBCCDD,  2'd1, 32'h1122CC44,  1'b0}; // byte 1 only
        vecs[13] = '{1'b1, 2'd2, 4'hF, 32'hFFFFFFFF,  2'd2, 32'd0,         1'b0}; // COUNT read-only
        vecs[14] = '{1'b1, 2'd3, 4'hF, 32'hFFFFFFFF,  2'd3, 32'd0,         1'b0}; // reserved
        vecs[15] = '{1'b1, 2'd0, 4'hE, 32'hFFFFFFF7,  2'd0, 32'h8,         1'b0}; // be[0]=0 keeps CTRL
        vecs[16] = '{1'b1, 2'd0, 4'h1, 32'hFFFFFFF2,  2'd0, 32'h2,         1'b0}; // upper bits dropped
        vecs[17] = '{1'b0, 2'd0, 4'h0, 32'd0,         2'd1, 32'h1122CC44,  1'b0}; // PRESET kept

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // One-shot latency and register access table
        for (int i = 0; i < 18; i++) begin
            step(1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].din);
            chk_dout($sformatf("vec%0d", i), vecs[i].chk_addr, vecs[i].exp_dout);
            chk_irq($sformatf("vec%0d", i), vecs[i].exp_irq);
        end

        // Periodic: PRESET=3, CTRL=0xB; pulse after E0+5, every 6 cycles
        do_reset();
        step(1'b0, 1'b1, 2'd1, 4'hF, 32'd3);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            idle();
            chk_irq($sformatf("periodic_k%0d", k), (k >= 5) && (((k - 5) % 6) == 0));
        end
        chk_dout("periodic_ctrl", 2'd0, 32'hB);

        // Masked expiry: PRESET=2, CTRL=0x1; flag at E0+4, EN cleared at E0+5
        do_reset();
        step(1'b0, 1'b1, 2'd1, 4'hF, 32'd2);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk_irq($sformatf("mask_k%0d", k), 1'b0);
        end
        chk_dout("mask_en_cleared", 2'd0, 32'h0);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h8);
        chk_irq("mask_after_im", 1'b0);
        idle();
        chk_irq("mask_after_im2", 1'b0);
        chk_dout("mask_count", 2'd2, 32'd0);

        // Pause: PRESET=10, CTRL=0x9; stop at COUNT=6, then restart
        do_reset();
        step(1'b0, 1'b1, 2'd1, 4'hF, 32'd10);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h9);
        for (int k = 1; k <= 6; k++) idle();
        chk_dout("pause_at6", 2'd2, 32'd6);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h8);
        chk_dout("pause_frozen", 2'd2, 32'd6);
        for (int k = 1; k <= 4; k++) idle();
        chk_dout("pause_held", 2'd2, 32'd6);
        chk_irq("pause_no_irq", 1'b0);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h9);
        idle();
        chk_dout("restart_1edge", 2'd2, 32'd6);
        idle();
        chk_dout("restart_reload", 2'd2, 32'd10);

        // Reset mid-count with a simultaneous write
        do_reset();
        step(1'b0, 1'b1, 2'd1, 4'hF, 32'd10);
        step(1'b0, 1'b1, 2'd0, 4'hF, 32'h9);
        for (int k = 1; k <= 5; k++) idle();
        chk_dout("pre_reset_count", 2'd2, 32'd7);
        step(1'b1, 1'b1, 2'd1, 4'hF, 32'h55);
        chk_all_zero("reset_midcount");
        for (int k = 1; k <= 5; k++) idle();
        chk_dout("no_reload", 2'd2, 32'd0);
        chk_dout("ctrl_stays0", 2'd0, 32'd0);
        chk_irq("no_irq_after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
